alu_share_ctrl: RTL and testbench

Sequencing controller that time-shares one combinational 32-bit ALU among `NUM_REQ` requesters (e.g. branch-compare unit, address generator, debug port) in the single-cycle MIPS datapath extensions. It arbitrates round-robin, latches the winner's operands and control code, drives the ALU for one cycle, registers result and zero flag, and returns them on a per-requester valid/ready response channel. The ALU itself is instantiated outside this block and connected through the `alu_*` ports.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/alu_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing controller: ALU control codes and FSM states.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SLT = 3'b110
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } share_state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request bit at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int cand_s;

    // Scan requesters starting at ptr and stop at the first pending one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand_s    = 32'sd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = ((int'(ptr) + k) >= NUM_REQ) ? (int'(ptr) + k - NUM_REQ) : (int'(ptr) + k);
            if (!any && req[cand_s[IDX_W-1:0]]) begin
                grant[cand_s[IDX_W-1:0]] = 1'b1;
                grant_idx                = cand_s[IDX_W-1:0];
                any                      = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU among NUM_REQ requesters.
// One transaction at a time: grant (IDLE) -> ALU cycle (EXEC) -> response (RESP).
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]    req_opa,
    input  logic [NUM_REQ*WIDTH-1:0]    req_opb,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [WIDTH-1:0]            rsp_result,
    output logic                        rsp_zero,
    output logic [WIDTH-1:0]            alu_opa,
    output logic [WIDTH-1:0]            alu_opb,
    output logic [ALU_CTRL_W-1:0]       alu_ctrl,
    input  logic [WIDTH-1:0]            alu_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1'b1);

    share_state_t            state_r;
    logic [IDX_W-1:0]        rr_ptr_r;
    logic [IDX_W-1:0]        owner_r;
    logic [WIDTH-1:0]        opa_r;
    logic [WIDTH-1:0]        opb_r;
    logic [ALU_CTRL_W-1:0]   ctrl_r;
    logic [WIDTH-1:0]        rsp_result_r;
    logic                    rsp_zero_r;
    logic [NUM_REQ-1:0]      rsp_valid_r;

    logic [NUM_REQ-1:0]      grant_s;
    logic [IDX_W-1:0]        grant_idx_s;
    logic                    any_s;
    logic [WIDTH-1:0]        sel_opa_s;
    logic [WIDTH-1:0]        sel_opb_s;
    logic [ALU_CTRL_W-1:0]   sel_ctrl_s;
    logic [IDX_W-1:0]        ptr_next_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    // Route the winning requester's operands and control code to the latch inputs.
    always_comb begin
        sel_opa_s  = '0;
        sel_opb_s  = '0;
        sel_ctrl_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_opa_s  = req_opa[i*WIDTH +: WIDTH];
                sel_opb_s  = req_opb[i*WIDTH +: WIDTH];
                sel_ctrl_s = req_ctrl[i*ALU_CTRL_W +: ALU_CTRL_W];
            end else begin
            end
        end
    end

    // Grant is only visible while idle and out of reset; the handshake must be same-cycle.
    always_comb begin
        if (!reset && (state_r == ST_IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer moves one past the owner that just completed, wrapping at NUM_REQ.
    always_comb begin
        if (owner_r == LAST_IDX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = owner_r + IDX_W'(1'b1);
        end
    end

    // Sequencer: latch winner, capture ALU result, hold response until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            owner_r      <= '0;
            opa_r        <= '0;
            opb_r        <= '0;
            ctrl_r       <= '0;
            rsp_result_r <= '0;
            rsp_zero_r   <= 1'b0;
            rsp_valid_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        opa_r   <= sel_opa_s;
                        opb_r   <= sel_opb_s;
                        ctrl_r  <= sel_ctrl_s;
                        owner_r <= grant_idx_s;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_result_r <= alu_result;
                    rsp_zero_r   <= (alu_result == '0);
                    rsp_valid_r  <= ONE_HOT0 << owner_r;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[owner_r]) begin
                        rsp_valid_r <= '0;
                        rr_ptr_r    <= ptr_next_s;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= '0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_opa    = opa_r;
    assign alu_opb    = opb_r;
    assign alu_ctrl   = ctrl_r;
    assign rsp_result = rsp_result_r;
    assign rsp_zero   = rsp_zero_r;
    assign rsp_valid  = rsp_valid_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural external ALU.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_opa;
    logic [N*W-1:0]  req_opb;
    logic [N*3-1:0]  req_ctrl;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [W-1:0]    rsp_result;
    logic            rsp_zero;
    logic [W-1:0]    alu_opa;
    logic [W-1:0]    alu_opb;
    logic [2:0]      alu_ctrl;
    logic [W-1:0]    alu_result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct { int idx; logic [W-1:0] res; logic zero; } exp_t;
    typedef struct { int idx; int cyc; } grant_t;
    exp_t   exp_q[$];
    grant_t grant_q[$];

    alu_share_ctrl #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_opa    (alu_opa),
        .alu_opb    (alu_opb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_opa & alu_opb;
            3'b001:  alu_result = alu_opa | alu_opb;
            3'b010:  alu_result = alu_opa + alu_opb;
            3'b100:  alu_result = alu_opa - alu_opb;
            3'b101:  alu_result = alu_opa * alu_opb;
            3'b110:  alu_result = ($signed(alu_opa) < $signed(alu_opb)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic void push_exp(input int idx, input logic [W-1:0] r, input logic z);
        exp_t e;
        e.idx = idx; e.res = r; e.zero = z;
        exp_q.push_back(e);
    endfunction

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        req_opa[idx*W +: W] = a;
        req_opb[idx*W +: W] = b;
        req_ctrl[idx*3 +: 3] = c;
        req_valid[idx] = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string name);
        int b = 0;
        while (grant_q.size() < n && b < 60) begin
            @(negedge clk); #1; b++;
        end
        if (grant_q.size() < n) chk({name, "_grant_timeout"}, 64'(grant_q.size()), 64'(n));
    endtask

    task automatic wait_rsp(input string name);
        int b = 0;
        while (rsp_valid == 4'b0000 && b < 20) begin
            @(negedge clk); #1; b++;
        end
        if (rsp_valid == 4'b0000) chk({name, "_rsp_timeout"}, 64'(rsp_valid), 64'hF);
    endtask

    task automatic wait_sb(input string name);
        int b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(negedge clk); #1; b++;
        end
        if (exp_q.size() != 0) chk({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: log grants and score every completed response handshake.
    always @(negedge clk) begin
        exp_t   e;
        grant_t g;
        if (req_ready != 4'b0000) begin
            g.idx = oh_idx(req_ready);
            g.cyc = cyc;
            grant_q.push_back(g);
        end
        if ((rsp_valid & rsp_ready) != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected rsp_valid=%b result=%0h", rsp_valid, rsp_result);
            end else begin
                e = exp_q.pop_front();
                chk("sb_owner",  64'(rsp_valid),  64'(4'b0001 << e.idx));
                chk("sb_result", 64'(rsp_result), 64'(e.res));
                chk("sb_zero",   64'(rsp_zero),   64'(e.zero));
            end
        end
    end

    initial begin
        int lat;
        int ord [5];
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_opa   = '0;
        req_opb   = '0;
        req_ctrl  = '0;
        rsp_ready = 4'b1111;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  64'(req_ready),  64'd0);
        chk("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_zero",   64'(rsp_zero),   64'd0);
        chk("rst_alu", 64'({alu_opa, alu_ctrl}) | 64'(alu_opb), 64'd0);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        reset     = 1'b0;

        // Single request: req 1 ADD 5+7, latency 2
        push_exp(1, 32'd12, 1'b0);
        @(posedge clk); #1;
        grant_q.delete();
        set_req(1, 32'd5, 32'd7, ALU_ADD);
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        lat = 1;
        @(negedge clk);
        while (rsp_valid == 4'b0000 && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        chk("t1_latency", 64'(lat), 64'd2);
        wait_sb("t1");

        // Reserved control code on req 2
        push_exp(2, 32'd0, 1'b1);
        @(posedge clk); #1;
        grant_q.delete();
        set_req(2, 32'h1234, 32'h5678, 3'b111);
        wait_grants(1, "t2");
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_sb("t2");

        // Wrap: ptr 3, req 0 (SUB 9-9) and req 2 (SUB 0x20-8) -> 0 then 2
        push_exp(0, 32'd0, 1'b1);
        push_exp(2, 32'h18, 1'b0);
        @(posedge clk); #1;
        grant_q.delete();
        set_req(0, 32'd9, 32'd9, ALU_SUB);
        set_req(2, 32'h20, 32'h8, ALU_SUB);
        wait_grants(1, "t3a");
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_grants(2, "t3b");
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        if (grant_q.size() >= 2) begin
            chk("t3_first",  64'(grant_q[0].idx), 64'd0);
            chk("t3_second", 64'(grant_q[1].idx), 64'd2);
        end
        wait_sb("t3");

        // req 3 OR moves pointer to 0
        push_exp(3, 32'hA5, 1'b0);
        @(posedge clk); #1;
        grant_q.delete();
        set_req(3, 32'hA0, 32'h05, ALU_OR);
        wait_grants(1, "t4");
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_sb("t4");

        // All four valid: order 0,1,2,3,0, three cycles apart
        push_exp(0, 32'h00F0_00FF, 1'b0);
        push_exp(1, 32'h1200_0034, 1'b0);
        push_exp(2, 32'd42, 1'b0);
        push_exp(3, 32'd1, 1'b0);
        push_exp(0, 32'h00F0_00FF, 1'b0);
        @(posedge clk); #1;
        grant_q.delete();
        set_req(0, 32'hF0F0_FFFF, 32'h0FF0_00FF, ALU_AND);
        set_req(1, 32'h1200_0000, 32'h0000_0034, ALU_OR);
        set_req(2, 32'd6, 32'd7, ALU_MUL);
        set_req(3, 32'd3, 32'd5, ALU_SLT);
        wait_grants(5, "t5");
        @(posedge clk); #1;
        req_valid = 4'b0000;
        ord = '{0, 1, 2, 3, 0};
        if (grant_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t5_order%0d", i), 64'(grant_q[i].idx), 64'(ord[i]));
                if (i > 0) chk($sformatf("t5_gap%0d", i), 64'(grant_q[i].cyc - grant_q[i-1].cyc), 64'd3);
            end
        end
        wait_sb("t5");

        // Backpressure on req 2; req 2 queues a second op meanwhile
        push_exp(2, 32'd123, 1'b0);
        push_exp(2, 32'h0F, 1'b0);
        @(posedge clk); #1;
        grant_q.delete();
        rsp_ready = 4'b1011;
        set_req(2, 32'd100, 32'd23, ALU_ADD);
        wait_grants(1, "t6a");
        @(posedge clk); #1;
        set_req(2, 32'hFF, 32'h0F, ALU_AND);
        wait_rsp("t6");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_ready",   64'(req_ready),  64'd0);
            chk("t6_valid_held", 64'(rsp_valid),  64'h4);
            chk("t6_result_held", 64'(rsp_result), 64'd123);
        end
        @(posedge clk); #1;
        rsp_ready = 4'b1111;
        wait_grants(2, "t6b");
        @(posedge clk); #1;
        req_valid = 4'b0000;
        if (grant_q.size() >= 2) chk("t6_regrant", 64'(grant_q[1].idx), 64'd2);
        wait_sb("t6");

        // Reset while in RESP: response dropped, pointer back to 0
        @(posedge clk); #1;
        grant_q.delete();
        rsp_ready = 4'b0111;
        set_req(3, 32'd1, 32'd1, ALU_ADD);
        wait_grants(1, "t7a");
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_rsp("t7");
        reset = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("t7_rsp_valid",  64'(rsp_valid),  64'd0);
        chk("t7_rsp_result", 64'(rsp_result), 64'd0);
        chk("t7_alu_opa",    64'(alu_opa),    64'd0);
        chk("t7_req_ready",  64'(req_ready),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        grant_q.delete();
        push_exp(2, 32'd1, 1'b0);
        push_exp(3, 32'd5, 1'b0);
        set_req(2, 32'd3, 32'd5, ALU_SLT);
        set_req(3, 32'd2, 32'd3, ALU_ADD);
        wait_grants(1, "t7b");
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_grants(2, "t7c");
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        if (grant_q.size() >= 2) begin
            chk("t7_ptr0_grant", 64'(grant_q[0].idx), 64'd2);
            chk("t7_next_grant", 64'(grant_q[1].idx), 64'd3);
        end
        wait_sb("t7");
        repeat (3) @(negedge clk);
        chk("end_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
